// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encodings, PS/2 reply codes and error codes for the command queue.
package ps2_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_XMIT  = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  typedef enum logic [1:0] {ERR_NONE, ERR_START, ERR_NAK, ERR_ACK} err_e;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: DEPTH x 8 synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module ps2_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/ps2_cmd_queue.sv
// ps2_cmd_queue: queues host command bytes and feeds them one at a time to ps2_send, waiting for each 0xFA ACK.
// Define PS2_RESEND_EN to retry a byte on 0xFE (up to MAX_RETRY times) instead of flagging an error.
module ps2_cmd_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 250000,
  parameter int START_WAIT  = 8
`ifdef PS2_RESEND_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_i,
  input  logic [7:0] wr_data_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       tx_send_o,
  output logic [7:0] tx_code_o,
  input  logic       tx_busy_i,
  input  logic       tx_rdy_i,
  input  logic       rx_strobe_i,
  input  logic [7:0] rx_code_i,
  output logic       err_o,
  output logic [1:0] err_code_o,
  input  logic       err_clr_i
);
  localparam int TW = $clog2(max2(ACK_TIMEOUT, START_WAIT) + 1);
  logic [2:0] state_q, state_d;
  logic [7:0] code_q, code_d, head;
  logic [TW-1:0] timer_q, timer_d;
  logic err_q, err_d, set_err, pop, fifo_empty;
  logic [1:0] err_code_q, err_code_d, new_code;
`ifdef PS2_RESEND_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
`endif
  ps2_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (wr_i),
    .pop_i   (pop),
    .data_i  (wr_data_i),
    .head_o  (head),
    .full_o  (full_o),
    .empty_o (fifo_empty)
  );
  // The in-flight byte stays at the FIFO head until it completes, so an empty FIFO means nothing in flight.
  assign empty_o    = fifo_empty;
  assign tx_send_o  = state_q == S_SEND;
  assign tx_code_o  = code_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    timer_d  = timer_q + TW'(timer_q != '1);
    set_err  = 1'b0;
    new_code = ERR_NONE;
    pop      = 1'b0;
`ifdef PS2_RESEND_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          code_d  = head;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        timer_d = '0;
        state_d = S_START;
      end
      S_START: begin
        if (tx_busy_i) state_d = S_XMIT;
        else if (timer_q == TW'(START_WAIT - 1)) begin
          set_err  = 1'b1;
          new_code = ERR_START;
        end
      end
      S_XMIT: begin
        timer_d = '0;
        if (!tx_busy_i) begin
          state_d  = S_ACK;
          set_err  = !tx_rdy_i;
          new_code = ERR_NAK;
        end
      end
      S_ACK: begin
        if (rx_strobe_i && rx_code_i == PS2_ACK) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else if (rx_strobe_i && rx_code_i == PS2_RESEND) begin
`ifdef PS2_RESEND_EN
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            code_d  = head;
            state_d = S_SEND;
          end else begin
            set_err  = 1'b1;
            new_code = ERR_ACK;
          end
`else
          set_err  = 1'b1;
          new_code = ERR_ACK;
`endif
        end else if (timer_q == TW'(ACK_TIMEOUT)) begin
          set_err  = 1'b1;
          new_code = ERR_ACK;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Every error abandons the current byte and moves on to the next one.
    if (set_err) begin
      pop     = 1'b1;
      state_d = S_IDLE;
    end
`ifdef PS2_RESEND_EN
    if (pop) retry_d = '0;
`endif
    err_d      = set_err || (err_q && !err_clr_i);
    err_code_d = set_err ? new_code : err_clr_i ? ERR_NONE : err_code_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef PS2_RESEND_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef PS2_RESEND_EN
      retry_q    <= retry_d;
`endif
    end
  end
endmodule

// File: tb/tb_ps2_cmd_queue.sv
// tb_ps2_cmd_queue: directed self-checking bench for ps2_cmd_queue; honours PS2_RESEND_EN.
module tb_ps2_cmd_queue;
  localparam int DEPTH = 4;
  localparam int ACK_TO = 200;
  localparam int SW = 8;
  logic clk = 0, reset = 1, wr = 0, tx_busy = 0, tx_rdy = 0, rx_strobe = 0, err_clr = 0;
  logic [7:0] wr_data = 0, rx_code = 0;
  logic full, empty, tx_send, err;
  logic [7:0] tx_code;
  logic [1:0] err_code;
  int n_chk = 0, n_fail = 0, sends = 0, base;
  logic [7:0] sent [$];

  ps2_cmd_queue #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO), .START_WAIT(SW)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_i        (wr),
    .wr_data_i   (wr_data),
    .full_o      (full),
    .empty_o     (empty),
    .tx_send_o   (tx_send),
    .tx_code_o   (tx_code),
    .tx_busy_i   (tx_busy),
    .tx_rdy_i    (tx_rdy),
    .rx_strobe_i (rx_strobe),
    .rx_code_i   (rx_code),
    .err_o       (err),
    .err_code_o  (err_code),
    .err_clr_i   (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_send) begin
    sends++;
    sent.push_back(tx_code);
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr = 1;
    wr_data = b;
    @(negedge clk);
    wr = 0;
  endtask

  task automatic pulse_clr();
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  // Device model: busy high for nbusy cycles, line-ACK bit rdy, then an optional reply byte.
  task automatic xfer(input int nbusy, input logic rdy, input logic reply, input logic [7:0] code);
    tx_busy = 1;
    repeat (nbusy) @(negedge clk);
    tx_busy = 0;
    tx_rdy = rdy;
    @(negedge clk);
    tx_rdy = 0;
    if (reply) begin
      repeat (2) @(negedge clk);
      rx_strobe = 1;
      rx_code = code;
      @(negedge clk);
      rx_strobe = 0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_code", tx_code, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);

    // 1: single byte, ACKed
    wr_byte(8'hED);
    chk("t1_no_early_send", tx_send, 0);
    @(negedge clk);
    chk("t1_send_latency", tx_send, 1);
    chk("t1_tx_code", tx_code, 8'hED);
    xfer(50, 1, 1, 8'hFA);
    chk("t1_sends", sends, 1);
    chk("t1_code", sent[0], 8'hED);
    chk("t1_empty", empty, 1);
    chk("t1_err", err, 0);

    // 2: three bytes back-to-back, strictly one at a time
    base = sends;
    wr_byte(8'hED);
    wr_byte(8'h02);
    wr_byte(8'hF4);
    xfer(20, 1, 1, 8'hFA);
    chk("t2_sends_a", sends, base + 1);
    xfer(20, 1, 1, 8'hFA);
    chk("t2_sends_b", sends, base + 2);
    xfer(20, 1, 1, 8'hFA);
    chk("t2_sends_c", sends, base + 3);
    chk("t2_code0", sent[base], 8'hED);
    chk("t2_code1", sent[base+1], 8'h02);
    chk("t2_code2", sent[base+2], 8'hF4);
    chk("t2_empty", empty, 1);

    // 3: overfill while busy never rises
    base = sends;
    for (int i = 0; i <= DEPTH; i++) wr_byte(8'h10 + 8'(i));
    chk("t3_full", full, 1);
    chk("t3_err_pending", err, 0);
    repeat (15) @(negedge clk);
    chk("t3_err", err, 1);
    chk("t3_err_code", err_code, 1);
    chk("t3_not_full", full, 0);
    repeat (60) @(negedge clk);
    chk("t3_empty", empty, 1);
    chk("t3_sends", sends, base + DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("t3_code", sent[base+i], 8'h10 + 8'(i));

    // 4: line NAK with err_clr in the same cycle, then the next byte
    pulse_clr();
    chk("t4_clr_err", err, 0);
    chk("t4_clr_code", err_code, 0);
    base = sends;
    wr_byte(8'hA1);
    wr_byte(8'hA2);
    tx_busy = 1;
    repeat (10) @(negedge clk);
    tx_busy = 0;
    tx_rdy = 0;
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("t4_nak_err", err, 1);
    chk("t4_nak_code", err_code, 2);
    xfer(10, 1, 1, 8'hFA);
    chk("t4_sends", sends, base + 2);
    chk("t4_code0", sent[base], 8'hA1);
    chk("t4_code1", sent[base+1], 8'hA2);
    chk("t4_empty", empty, 1);
    chk("t4_err_sticky", err_code, 2);
    pulse_clr();
    chk("t4_clr2_err", err, 0);
    chk("t4_clr2_code", err_code, 0);

    // 5: ACK timeout, then a non-ACK reply is ignored
    wr_byte(8'hB1);
    xfer(10, 1, 0, 8'h00);
    repeat (ACK_TO - 5) @(negedge clk);
    chk("t5_wait_err", err, 0);
    chk("t5_wait_empty", empty, 0);
    repeat (10) @(negedge clk);
    chk("t5_to_err", err, 1);
    chk("t5_to_code", err_code, 3);
    chk("t5_to_empty", empty, 1);
    pulse_clr();
    wr_byte(8'hB2);
    xfer(10, 1, 0, 8'h00);
    repeat (5) @(negedge clk);
    rx_strobe = 1;
    rx_code = 8'hAA;
    @(negedge clk);
    rx_strobe = 0;
    repeat (5) @(negedge clk);
    chk("t5_aa_empty", empty, 0);
    chk("t5_aa_err", err, 0);
    rx_strobe = 1;
    rx_code = 8'hFA;
    @(negedge clk);
    rx_strobe = 0;
    chk("t5_ack_empty", empty, 1);
    chk("t5_ack_err", err, 0);

    // 6: 0xFE handling
    base = sends;
    wr_byte(8'hC1);
`ifdef PS2_RESEND_EN
    xfer(10, 1, 1, 8'hFE);
    xfer(10, 1, 1, 8'hFE);
    xfer(10, 1, 1, 8'hFA);
    chk("t6_sends", sends, base + 3);
    for (int i = 0; i < 3; i++) chk("t6_code", sent[base+i], 8'hC1);
    chk("t6_err", err, 0);
    chk("t6_empty", empty, 1);
    base = sends;
    wr_byte(8'hC2);
    for (int i = 0; i < 4; i++) xfer(10, 1, 1, 8'hFE);
    chk("t6_max_sends", sends, base + 4);
    chk("t6_max_err", err, 1);
    chk("t6_max_code", err_code, 3);
    chk("t6_max_empty", empty, 1);
`else
    xfer(10, 1, 1, 8'hFE);
    chk("t6_sends", sends, base + 1);
    chk("t6_err", err, 1);
    chk("t6_code", err_code, 3);
    chk("t6_empty", empty, 1);
`endif

    // reset mid-XMIT flushes the queue
    wr_byte(8'hD1);
    wr_byte(8'hD2);
    tx_busy = 1;
    repeat (5) @(negedge clk);
    base = sends;
    reset = 1;
    @(negedge clk);
    chk("rm_empty", empty, 1);
    chk("rm_tx_send", tx_send, 0);
    chk("rm_tx_code", tx_code, 0);
    chk("rm_err", err, 0);
    reset = 0;
    tx_busy = 0;
    repeat (20) @(negedge clk);
    chk("rm_no_send", sends, base);
    chk("rm_still_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
